// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel: registered N:1 lane selector with a 2-entry output buffer.
//
// Each accepted beat carries a lane index (sel) and a flattened input bus (inp).
// The selected lane is captured together with an error bit into a 2-entry FIFO.
// A sel outside 0..N_INP-1 yields DEFAULT_VAL with the error bit set.
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   in_valid   in   beat offered on sel/inp
//   in_ready   out  a beat can be accepted this cycle (registered decode only)
//   sel        in   lane index, lane k = inp[k*W +: W]
//   inp        in   flattened input lanes, lane 0 in the LSBs
//   out_valid  out  out/out_err hold a valid beat (head of the buffer)
//   out_ready  in   consumer takes the head beat this cycle
//   out        out  selected lane value or DEFAULT_VAL
//   out_err    out  1 when the head beat had sel >= N_INP
//   err_cnt    out  saturating count of accepted out-of-range beats
//                   (present only when MUX_ERR_CNT_EN is defined)
//
// Optional feature macro: MUX_ERR_CNT_EN

module mux_pipe_sel #(
   parameter int unsigned N_INP       = 31,
   parameter int unsigned W           = 2,
   parameter int unsigned DEFAULT_VAL = 1,
   localparam int unsigned SEL_W      = $clog2(N_INP)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N_INP*W-1:0] inp,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out,
   output logic               out_err
`ifdef MUX_ERR_CNT_EN
   ,
   output logic [7:0]         err_cnt
`endif
);

   localparam logic [W-1:0] DefaultLane = W'(DEFAULT_VAL);

   typedef struct packed {
      logic         err;
      logic [W-1:0] val;
   } entry_t;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e state_q, state_d;
   entry_t head_q, head_d;
   entry_t tail_q, tail_d;
   logic   ready_en_q;
   entry_t new_entry;
   logic   accept;
   logic   pop;

   // Lane decode: walk every legal index so an out-of-range sel never indexes
   // past the bus and the default is taken without any X.
   always_comb begin
      new_entry.val = DefaultLane;
      new_entry.err = 1'b1;
      for (int unsigned k = 0; k < N_INP; k++) begin
         if (32'(sel) == k) begin
            new_entry.val = inp[k*W +: W];
            new_entry.err = 1'b0;
         end
      end
   end

   // in_ready depends only on flops, never on out_ready. ready_en_q keeps it low
   // during reset and for the first edge after release.
   always_comb begin
      in_ready  = ready_en_q && (state_q != StFull);
      out_valid = (state_q != StEmpty);
      out       = head_q.val;
      out_err   = head_q.err;
      accept    = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               head_d  = new_entry;
               state_d = StOne;
            end
         end
         StOne: begin
            if (accept && !pop) begin
               tail_d  = new_entry;
               state_d = StFull;
            end else if (pop && !accept) begin
               state_d = StEmpty;
            end else if (accept && pop) begin
               // Old head leaves as the new beat arrives; it becomes the head.
               head_d = new_entry;
            end
         end
         StFull: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StEmpty;
         head_q     <= '0;
         tail_q     <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         ready_en_q <= 1'b1;
      end
   end

`ifdef MUX_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts at accept time and saturates at 255.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && new_entry.err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_pipe_sel.sv
module tb_mux_pipe_sel;

   logic        CLK;
   logic        RST_N;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  sel;
   logic [61:0] inp;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out;
   logic        out_err;
`ifdef MUX_ERR_CNT_EN
   logic [7:0]  err_cnt;
   logic [7:0]  err_cnt4;
   logic [7:0]  err_cnt5;
`endif

   // Small-parameter instances
   logic        p_valid;
   logic        p4_ready, p5_ready;
   logic [1:0]  p4_sel;
   logic [2:0]  p5_sel;
   logic [31:0] p4_inp;
   logic [39:0] p5_inp;
   logic        p4_ovalid, p5_ovalid;
   logic [7:0]  p4_out, p5_out;
   logic        p4_err, p5_err;

   int checks;
   int failures;

   mux_pipe_sel #(.N_INP(31), .W(2), .DEFAULT_VAL(1)) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .inp       (inp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_err   (out_err)
`ifdef MUX_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   mux_pipe_sel #(.N_INP(4), .W(8), .DEFAULT_VAL(1)) u_p4 (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (p_valid),
      .in_ready  (p4_ready),
      .sel       (p4_sel),
      .inp       (p4_inp),
      .out_valid (p4_ovalid),
      .out_ready (1'b1),
      .out       (p4_out),
      .out_err   (p4_err)
`ifdef MUX_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt4)
`endif
   );

   mux_pipe_sel #(.N_INP(5), .W(8), .DEFAULT_VAL(1)) u_p5 (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (p_valid),
      .in_ready  (p5_ready),
      .sel       (p5_sel),
      .inp       (p5_inp),
      .out_valid (p5_ovalid),
      .out_ready (1'b1),
      .out       (p5_out),
      .out_err   (p5_err)
`ifdef MUX_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt5)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic       vld;
      logic [4:0] sel;
      logic       ordy;
      logic       e_ovalid;
      logic [1:0] e_out;
      logic       e_err;
      logic       e_irdy;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_beat(input string name, input logic [1:0] e_out, input logic e_err,
                           input logic e_irdy);
      chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({name, ".out"}, 32'(out), 32'(e_out));
      chk({name, ".out_err"}, 32'(out_err), 32'(e_err));
      chk({name, ".in_ready"}, 32'(in_ready), 32'(e_irdy));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      RST_N     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sel       = '0;
      p_valid   = 1'b0;
      p4_sel    = '0;
      p5_sel    = '0;
      p4_inp    = 32'hA1B2_C3D4;
      p5_inp    = 40'h55_A1B2_C3D4;
      for (int k = 0; k < 31; k++) inp[k*2 +: 2] = 2'(k % 4);

      //           vld  sel    ordy  ov    out   err   irdy
      vecs[0]  = '{1'b1, 5'd5,  1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 5'd31, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 5'd7,  1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 5'd6,  1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 5'd27, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 5'd0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 5'd13, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1};

      // Reset state
      #2;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out", 32'(out), 32'd0);
      chk("rst.out_err", 32'(out_err), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk("rst_rel.in_ready", 32'(in_ready), 32'd1);
      chk("rst_rel.out_valid", 32'(out_valid), 32'd0);

      // Sweep all legal selects back-to-back
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int s = 0; s < 31; s++) begin
         sel = 5'(s);
         tick();
         chk_beat($sformatf("sweep[%0d]", s), 2'(s % 4), 1'b0, 1'b1);
      end
      in_valid = 1'b0;
      tick();
      chk("sweep_drain.out_valid", 32'(out_valid), 32'd0);

      // Table vectors, starting from an empty buffer
      for (int i = 0; i < 12; i++) begin
         in_valid  = vecs[i].vld;
         sel       = vecs[i].sel;
         out_ready = vecs[i].ordy;
         tick();
         chk($sformatf("vec[%0d].out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovalid));
         chk($sformatf("vec[%0d].in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
         if (vecs[i].e_ovalid) begin
            chk($sformatf("vec[%0d].out", i), 32'(out), 32'(vecs[i].e_out));
            chk($sformatf("vec[%0d].out_err", i), 32'(out_err), 32'(vecs[i].e_err));
         end
      end

      // Backpressure: three beats offered while blocked, all must emerge in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel = 5'd2; tick(); chk_beat("bp.a", 2'd2, 1'b0, 1'b1);
      sel = 5'd3; tick(); chk_beat("bp.b", 2'd2, 1'b0, 1'b0);
      sel = 5'd4; tick(); chk_beat("bp.c", 2'd2, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick(); chk_beat("bp.d", 2'd3, 1'b0, 1'b1);
      tick(); chk_beat("bp.e", 2'd0, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick();
      chk("bp_drain.out_valid", 32'(out_valid), 32'd0);

      // Simultaneous accept and pop from ONE
      in_valid = 1'b1;
      sel = 5'd1;
      tick(); chk_beat("sim.start", 2'd1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         sel = 5'(i + 2);
         tick();
         chk_beat($sformatf("sim[%0d]", i), 2'((i + 2) % 4), 1'b0, 1'b1);
      end
      in_valid = 1'b0;
      tick();
      chk("sim_drain.out_valid", 32'(out_valid), 32'd0);

      // Reset mid-stream with two buffered beats
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel = 5'd3; tick();
      sel = 5'd31; tick();
      in_valid = 1'b0;
      chk("pre_rst.in_ready", 32'(in_ready), 32'd0);
      RST_N = 1'b0;
      #1;
      chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst.out", 32'(out), 32'd0);
      chk("mid_rst.out_err", 32'(out_err), 32'd0);
      chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
      #2;
      RST_N = 1'b1;
      tick();
      chk("mid_rel.in_ready", 32'(in_ready), 32'd1);
      chk("mid_rel.out_valid", 32'(out_valid), 32'd0);

      // Other parameterisations
      p_valid = 1'b1;
      p4_sel  = 2'd3;
      p5_sel  = 3'd7;
      tick();
      chk("p4.sel3.out", 32'(p4_out), 32'hA1);
      chk("p4.sel3.err", 32'(p4_err), 32'd0);
      chk("p5.sel7.out", 32'(p5_out), 32'h01);
      chk("p5.sel7.err", 32'(p5_err), 32'd1);
      p4_sel = 2'd0;
      p5_sel = 3'd4;
      tick();
      chk("p4.sel0.out", 32'(p4_out), 32'hD4);
      chk("p5.sel4.out", 32'(p5_out), 32'h55);
      chk("p5.sel4.err", 32'(p5_err), 32'd0);
      p_valid = 1'b0;
      tick();
      chk("p4.drain.out_valid", 32'(p4_ovalid), 32'd0);

      // Out-of-range select and error counter saturation
      out_ready = 1'b1;
      in_valid  = 1'b1;
      sel = 5'd31;
      tick();
      chk_beat("oor", 2'd1, 1'b1, 1'b1);
`ifdef MUX_ERR_CNT_EN
      chk("err_cnt.one", 32'(err_cnt), 32'd1);
      for (int i = 0; i < 299; i++) tick();
      chk("err_cnt.sat", 32'(err_cnt), 32'd255);
`endif
      in_valid = 1'b0;
      tick();
      chk("end.out_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
